// File: rtl/fetch_bridge_pkg.sv
// Shared types and constants for the instruction-side fetch bridge.
// State encoding, bus size code and fetch-width limit.
package fetch_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD,
    DRAIN
  } state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int FETCH_WIDTH_MAX = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch bridge performance counters: address handshakes and stall cycles.
// Both counters wrap naturally at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_fire,
  input  logic        stall,
  output logic [31:0] req_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (req_fire)
        req_cnt <= req_cnt + 32'd1;
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/i_sram_like_fetch_bridge.sv
// Fetch-stage sram port to sram-like instruction bus bridge, FETCH_WIDTH slots.
// Optional FETCH_PERF_CNT_EN adds request/stall performance counters.
module i_sram_like_fetch_bridge
  import fetch_bridge_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_sram_en,
  input  logic [ADDR_W-1:0]        inst_sram_addr,
  input  logic                     flush,
  input  logic                     longest_stall,
  output logic [32*FETCH_WIDTH-1:0] inst_sram_rdata,
  output logic [FETCH_WIDTH-1:0]   inst_sram_data_ok,
  output logic                     i_stall,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]              perf_req_cnt,
  output logic [31:0]              perf_stall_cnt,
`endif
  output logic                     inst_req,
  output logic                     inst_wr,
  output logic [1:0]               inst_size,
  output logic [ADDR_W-1:0]        inst_addr,
  output logic [31:0]              inst_wdata,
  input  logic                     inst_addr_ok,
  input  logic [FETCH_WIDTH-1:0]   inst_data_ok,
  input  logic [32*FETCH_WIDTH-1:0] inst_rdata
);

  state_e state_q, state_d;
  logic   fp_q, fp_d;

  logic [ADDR_W-1:0]        addr_q;
  logic [32*FETCH_WIDTH-1:0] rdata_q;
  logic [FETCH_WIDTH-1:0]   mask_q;

  logic req, stall;
  logic addr_ld, cap, clr;
  logic beat;

  assign beat = inst_data_ok[0];

  always_comb begin
    state_d = state_q;
    fp_d    = fp_q;
    req     = 1'b0;
    stall   = 1'b0;
    addr_ld = 1'b0;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req     = inst_sram_en & ~flush;
        stall   = inst_sram_en;
        addr_ld = req;
        if (req)
          state_d = inst_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        req   = 1'b1;
        stall = 1'b1;
        if (flush)
          fp_d = 1'b1;
        if (inst_addr_ok)
          state_d = (fp_q | flush) ? DRAIN : DATA;
      end
      DATA: begin
        stall = 1'b1;
        if (beat) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (~longest_stall | flush | ~inst_sram_en) begin
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        stall = inst_sram_en;
        if (beat) begin
          fp_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fp_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      if (addr_ld)
        addr_q <= inst_sram_addr;
      if (cap) begin
        rdata_q <= inst_rdata;
        mask_q  <= inst_data_ok;
      end else if (clr) begin
        mask_q <= '0;
      end
    end
  end

  // Bus-facing strobes are forced low while reset is held, whatever the datapath drives.
  assign inst_req = req & rst;
  assign i_stall  = stall & rst;
  assign inst_addr = !rst ? '0 :
                     (state_q == IDLE) ? inst_sram_addr : addr_q;

  assign inst_wr    = 1'b0;
  assign inst_size  = SIZE_WORD;
  assign inst_wdata = 32'd0;

  assign inst_sram_rdata   = rdata_q;
  assign inst_sram_data_ok = (state_q == HOLD) ? mask_q : '0;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst),
    .req_fire  (inst_req & inst_addr_ok),
    .stall     (i_stall),
    .req_cnt   (perf_req_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_i_sram_like_fetch_bridge.sv
// Testbench for i_sram_like_fetch_bridge (FETCH_WIDTH=2).
// Transaction-level expectations, randomized latencies, masks and data.
module tb_i_sram_like_fetch_bridge;

  localparam int FW = 2;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [AW-1:0]  sram_addr;
  logic           flush;
  logic           lstall;
  logic [32*FW-1:0] sram_rdata;
  logic [FW-1:0]  sram_ok;
  logic           i_stall;
  logic           inst_req;
  logic           inst_wr;
  logic [1:0]     inst_size;
  logic [AW-1:0]  inst_addr;
  logic [31:0]    inst_wdata;
  logic           addr_ok;
  logic [FW-1:0]  data_ok;
  logic [32*FW-1:0] rdata;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]    perf_req_cnt;
  logic [31:0]    perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i_sram_like_fetch_bridge #(.FETCH_WIDTH(FW), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_sram_en      (en),
    .inst_sram_addr    (sram_addr),
    .flush             (flush),
    .longest_stall     (lstall),
    .inst_sram_rdata   (sram_rdata),
    .inst_sram_data_ok (sram_ok),
    .i_stall           (i_stall),
`ifdef FETCH_PERF_CNT_EN
    .perf_req_cnt      (perf_req_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
`endif
    .inst_req          (inst_req),
    .inst_wr           (inst_wr),
    .inst_size         (inst_size),
    .inst_addr         (inst_addr),
    .inst_wdata        (inst_wdata),
    .inst_addr_ok      (addr_ok),
    .inst_data_ok      (data_ok),
    .inst_rdata        (rdata)
  );

  function automatic logic [32*FW-1:0] rnd_data();
    logic [32*FW-1:0] v;
    for (int i = 0; i < FW; i++)
      v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [FW-1:0] rnd_nobeat();
    logic [FW-1:0] v;
    v = FW'($urandom);
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; sram_addr = '0; flush = 1'b0; lstall = 1'b0;
    addr_ok = 1'b0; data_ok = '0; rdata = '0;
  endtask

  // One complete fetch: address phase, data phase, HOLD with `hold` stalled cycles.
  task automatic fetch(input logic [AW-1:0] a, input int alat, input int dlat,
                       input logic [FW-1:0] m, input logic [32*FW-1:0] d,
                       input int hold, input bit drop_en);
    for (int c = 0; c <= alat; c++) begin
      en = !(drop_en && c > 0);
      sram_addr = (c == 0) ? a : AW'($urandom);
      addr_ok = (c == alat); flush = 1'b0; data_ok = '0; rdata = rnd_data();
      #1;
      checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL addr_req c=%0d got %0b exp 1", c, inst_req); end
      checks++; if (inst_addr !== a) begin errors++; $display("FAIL addr_hold c=%0d got %h exp %h", c, inst_addr, a); end
      checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL addr_stall c=%0d got %0b exp 1", c, i_stall); end
      checks++; if (sram_ok !== '0) begin errors++; $display("FAIL addr_ok_out c=%0d got %b exp 0", c, sram_ok); end
      step();
    end
    addr_ok = 1'b0; en = 1'b1;
    for (int k = 0; k <= dlat; k++) begin
      data_ok = (k == dlat) ? m : rnd_nobeat();
      rdata = (k == dlat) ? d : rnd_data();
      #1;
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL data_req k=%0d got %0b exp 0", k, inst_req); end
      checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL data_stall k=%0d got %0b exp 1", k, i_stall); end
      checks++; if (sram_ok !== '0) begin errors++; $display("FAIL data_ok_out k=%0d got %b exp 0", k, sram_ok); end
      step();
    end
    data_ok = '0;
    for (int h = 0; h <= hold; h++) begin
      lstall = (h < hold); rdata = rnd_data();
      #1;
      checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL hold_stall h=%0d got %0b exp 0", h, i_stall); end
      checks++; if (sram_ok !== m) begin errors++; $display("FAIL hold_mask h=%0d got %b exp %b", h, sram_ok, m); end
      checks++; if (sram_rdata !== d) begin errors++; $display("FAIL hold_rdata h=%0d got %h exp %h", h, sram_rdata, d); end
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL hold_req h=%0d got %0b exp 0", h, inst_req); end
      step();
    end
    lstall = 1'b0;
  endtask

  task automatic quiet_cycle(input string tag);
    en = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = '0;
    #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL %s_req got %0b exp 0", tag, inst_req); end
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL %s_stall got %0b exp 0", tag, i_stall); end
    checks++; if (sram_ok !== '0) begin errors++; $display("FAIL %s_ok got %b exp 0", tag, sram_ok); end
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) step();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", inst_req); end
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", i_stall); end
    checks++; if (inst_addr !== '0) begin errors++; $display("FAIL rst_addr got %h exp 0", inst_addr); end
    checks++; if (sram_rdata !== '0) begin errors++; $display("FAIL rst_rdata got %h exp 0", sram_rdata); end
    checks++; if (sram_ok !== '0) begin errors++; $display("FAIL rst_ok got %b exp 0", sram_ok); end
    checks++; if (inst_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %0b exp 0", inst_wr); end
    checks++; if (inst_size !== 2'b10) begin errors++; $display("FAIL rst_size got %b exp 10", inst_size); end
    checks++; if (inst_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", inst_wdata); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_and_back_to_back();
    fetch(32'hBFC0_0000, 0, 0, 2'b11, {32'h2402_0002, 32'h2401_0001}, 0, 1'b0);
    fetch(32'hBFC0_0008, 0, 0, 2'b11, rnd_data(), 0, 1'b0);
    quiet_cycle("b2b_end");
  endtask

  task automatic test_partial_mask();
    fetch(32'hBFC0_0010, 0, 1, 2'b01, rnd_data(), 1, 1'b0);
    quiet_cycle("mask_end");
  endtask

  task automatic test_delayed_addr_ok();
    fetch(32'hBFC0_0020, 3, 0, 2'b11, rnd_data(), 0, 1'b1);
    quiet_cycle("delay_end");
  endtask

  task automatic test_long_stall();
    fetch(32'hBFC0_0030, 1, 2, 2'b11, rnd_data(), 4, 1'b0);
    quiet_cycle("lstall_end");
  endtask

  task automatic test_flush_data();
    en = 1'b1; sram_addr = 32'hBFC0_0040; addr_ok = 1'b1;
    step();
    addr_ok = 1'b0; flush = 1'b1; sram_addr = 32'hBFC0_0380;
    #1;
    checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fdata_stall got %0b exp 1", i_stall); end
    step();
    flush = 1'b0; data_ok = 2'b11; rdata = rnd_data();
    #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL drain_req got %0b exp 0", inst_req); end
    checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL drain_stall got %0b exp 1", i_stall); end
    checks++; if (sram_ok !== '0) begin errors++; $display("FAIL drain_ok got %b exp 0", sram_ok); end
    step();
    data_ok = '0;
    fetch(32'hBFC0_0380, 0, 0, 2'b11, rnd_data(), 0, 1'b0);
    quiet_cycle("fdata_end");
  endtask

  task automatic test_flush_same_cycle();
    en = 1'b1; sram_addr = 32'hBFC0_0050; addr_ok = 1'b1;
    step();
    addr_ok = 1'b0; flush = 1'b1; data_ok = 2'b11; rdata = rnd_data();
    step();
    quiet_cycle("fsame_a");
    quiet_cycle("fsame_b");
  endtask

  task automatic test_flush_addr();
    en = 1'b1; sram_addr = 32'hBFC0_0060; addr_ok = 1'b0;
    step();
    en = 1'b0; flush = 1'b1; sram_addr = 32'h1234_5678;
    #1;
    checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL faddr_req got %0b exp 1", inst_req); end
    checks++; if (inst_addr !== 32'hBFC0_0060) begin errors++; $display("FAIL faddr_addr got %h exp bfc00060", inst_addr); end
    step();
    flush = 1'b0; addr_ok = 1'b1;
    #1;
    checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL faddr_req2 got %0b exp 1", inst_req); end
    step();
    addr_ok = 1'b0; data_ok = 2'b01; rdata = rnd_data();
    #1;
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL faddr_drain_stall got %0b exp 0", i_stall); end
    checks++; if (sram_ok !== '0) begin errors++; $display("FAIL faddr_drain_ok got %b exp 0", sram_ok); end
    step();
    quiet_cycle("faddr_end");
    fetch(32'hBFC0_0070, 0, 0, 2'b11, rnd_data(), 0, 1'b0);
    quiet_cycle("faddr_next");
  endtask

  task automatic test_reset_mid_data();
    en = 1'b1; sram_addr = 32'hBFC0_0090; addr_ok = 1'b1;
    step();
    addr_ok = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %0b exp 0", inst_req); end
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %0b exp 0", i_stall); end
    checks++; if (sram_rdata !== '0) begin errors++; $display("FAIL rmid_rdata got %h exp 0", sram_rdata); end
    step();
    rst = 1'b1; en = 1'b0; data_ok = 2'b11; rdata = rnd_data();
    #1;
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL rlate_stall got %0b exp 0", i_stall); end
    step();
    quiet_cycle("rlate_a");
    fetch(32'hBFC0_00A0, 0, 0, 2'b11, rnd_data(), 0, 1'b0);
    quiet_cycle("rlate_end");
  endtask

  task automatic test_random();
    logic [FW-1:0] m;
    for (int i = 0; i < 24; i++) begin
      m = FW'($urandom);
      m[0] = 1'b1;
      fetch({$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 3), $urandom_range(0, 3),
            m, rnd_data(), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 1) == 1)
        quiet_cycle("rnd_gap");
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_basic_and_back_to_back();
    test_partial_mask();
    test_delayed_addr_ok();
    test_long_stall();
    test_flush_data();
    test_flush_same_cycle();
    test_flush_addr();
    test_reset_mid_data();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
